mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Responder end of the processor's data-memory bus: serves the core's store/load accesses (we, a, wd → rd).
- Combines word RAM with a small memory-mapped peripheral page:
  - LED register
  - free-running cycle counter
  - 4-deep transmit FIFO with a valid/ready output stream
  - status register
- Drop-in replacement for the plain data memory beside the processor, on the same clock.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words (power of two).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- we  in  1  write strobe from the core for the current access.
- a  in  32  byte address; a[1:0] ignored everywhere.
- wd  in  32  write data.
- rd  out  32  read data, combinational from a.
- leds  out  8  LED register contents.
- tx_data  out  32  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts head when high with tx_valid.

Behaviour:

Address map:
- RAM: a < RAM_WORDS*4.
- LED: 0xFFFF_0000, R/W; bits[7:0] stored, upper bits read 0.
- CNT: 0xFFFF_0004, read-only.
- TXD: 0xFFFF_0008, write pushes; reads 0.
- STAT: 0xFFFF_000C.
  - bit0 full, bit1 empty, bits[4:2] count, bit5 overflow (sticky); other bits 0.
  - Writing with wd[5]=1 clears overflow; other bits ignored.
- Anything else: reads 0, writes ignored.

Reads and writes:
- Reads are combinational (zero latency), like the existing data memory.
- Writes take effect at the rising edge where we=1.
- A read of a location in the same cycle as a write to it returns the old value.

Reset (reset=0, asynchronous):
- leds=0, counter=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0.
- RAM contents are not reset.
- Reset mid-push or mid-pop discards all FIFO contents.

Counter:
- +1 every clock while reset=1.
- Wraps 0xFFFF_FFFF → 0.
- Writes to CNT are ignored.

FIFO:
- Circular buffer with read/write pointers plus a count of 0..FIFO_DEPTH.
- Push: we=1 and a=TXD.
- Pop: tx_valid & tx_ready.
- tx_data = entry at read pointer; 0 when empty.
- Push when full without a simultaneous pop: data dropped, overflow set, count unchanged.
- Push and pop in the same cycle:
  - non-empty: both succeed, count unchanged (full case included, so no overflow).
  - empty: push only, since tx_valid=0.
- Pointers wrap modulo FIFO_DEPTH.
- tx_valid depends only on FIFO state, never on tx_ready (no combinational path ready→valid).
- STAT read reflects pre-edge state.

Test Plan:
- Release reset, write 0xDEADBEEF to 0x10, read 0x10; read 0x13 → rd=0xDEADBEEF at both; read 0x5000 → 0.
- Write 0x1A5 to LED → leds=0xA5, LED read=0x000000A5; assert reset=0 mid-run → leds=0 immediately without a clock edge.
- Hold reset=1 for 10 cycles after release, read CNT → 10 (±1 by sample point); force counter to 0xFFFFFFFF → next cycle 0.
- tx_ready=0; push 1, 2, 3, 4, 5 → STAT=0x31 (overflow, count 4, full); tx_data=1. Raise tx_ready → pops 1, 2, 3, 4 on consecutive cycles, then STAT=0x22 (overflow, empty). Write STAT with wd=0x20 → STAT=0x02.
- FIFO full and tx_ready=1; push 9 in the same cycle → count stays 4, overflow stays 0, and 9 emerges fourth from now.
- FIFO empty; push 7 with tx_ready=1 held → tx_valid rises the next cycle with tx_data=7, pops the following edge, and the FIFO returns to empty.

Source files
------------

// File: rtl/mmio_responder.sv
// Data-memory responder: word RAM plus LED, cycle counter, TX FIFO and status page.
// Reads are combinational, writes land on the clock edge; a full TX FIFO drops pushes and sets sticky overflow.
module mmio_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  leds,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [31:0] ADDR_LED  = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_CNT  = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TXD  = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_STAT = 32'hFFFF_000C;

    // Storage
    logic [31:0]   r_mem [RAM_WORDS];
    logic [31:0]   r_fifo_mem [FIFO_DEPTH];
    logic [7:0]    r_leds;
    logic [31:0]   r_cycles;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    // Decode on the word address; the byte offset never matters
    logic          w_sel_ram;
    logic          w_sel_led;
    logic          w_sel_cnt;
    logic          w_sel_txd;
    logic          w_sel_stat;
    logic [AW-1:0] w_ram_idx;

    assign w_sel_ram  = (a[31:AW+2] == '0);
    assign w_sel_led  = (a[31:2] == ADDR_LED[31:2]);
    assign w_sel_cnt  = (a[31:2] == ADDR_CNT[31:2]);
    assign w_sel_txd  = (a[31:2] == ADDR_TXD[31:2]);
    assign w_sel_stat = (a[31:2] == ADDR_STAT[31:2]);
    assign w_ram_idx  = a[AW+1:2];

    // FIFO status and handshake
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic [31:0]   w_count_ext;
    logic [31:0]   w_stat;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign tx_valid    = ~w_empty;
    assign w_pop       = tx_valid & tx_ready;
    assign w_push      = we & w_sel_txd;
    // A pop in the same edge frees the slot, so a push into a full FIFO still lands
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign tx_data     = w_empty ? 32'd0 : r_fifo_mem[r_rd_ptr];
    assign w_count_ext = 32'(r_count);
    assign w_stat      = {26'd0, r_ovf, w_count_ext[2:0], w_empty, w_full};
    assign leds        = r_leds;

    logic w_unused;
    assign w_unused = ^{a[1:0], w_count_ext[31:3]};

    always_comb begin
        rd = 32'd0;
        if (w_sel_ram) begin
            rd = r_mem[w_ram_idx];
        end else if (w_sel_led) begin
            rd = {24'd0, r_leds};
        end else if (w_sel_cnt) begin
            rd = r_cycles;
        end else if (w_sel_stat) begin
            rd = w_stat;
        end
    end

    // RAM and FIFO payload are deliberately not reset
    always_ff @(posedge clk) begin
        if (we && w_sel_ram) begin
            r_mem[w_ram_idx] <= wd;
        end
        if (w_push_ok) begin
            r_fifo_mem[r_wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds   <= 8'd0;
            r_cycles <= 32'd0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (we && w_sel_led) begin
                r_leds <= wd[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (we && w_sel_stat && wd[5]) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus a randomized run against a queue-based model.
module tb_mmio_responder;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0004;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_ram [64];
    bit          m_ram_ok [64];
    logic [31:0] m_q [$];
    logic [7:0]  m_leds;
    bit          m_ovf;

    mmio_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
        .leds(leds), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL reset_leds: got %h want 00", leds); end
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 32'd0) begin n_errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        a = A_STAT; #1;
        n_checks++; if (rd !== 32'h2) begin n_errors++; $display("FAIL reset_stat: got %h want 00000002", rd); end
        a = A_CNT; #1;
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL reset_cnt: got %h want 0", rd); end
    endtask

    task automatic test_counter();
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        a = A_CNT; we = 1'b1; wd = 32'h55; #1;
        n_checks++; if (rd !== 32'd10) begin n_errors++; $display("FAIL cnt_after_10: got %0d want 10", rd); end
        @(negedge clk);
        we = 1'b0; #1;
        n_checks++; if (rd !== 32'd11) begin n_errors++; $display("FAIL cnt_write_ignored: got %0d want 11", rd); end
        force dut.r_cycles = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL cnt_read_max: got %h want ffffffff", rd); end
        release dut.r_cycles;
        @(negedge clk); #1;
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL cnt_wrap: got %h want 0", rd); end
    endtask

    task automatic test_ram();
        @(negedge clk);
        we = 1'b1; a = 32'h10; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we = 1'b0; #1;
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read_10: got %h want deadbeef", rd); end
        a = 32'h13; #1;
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_read_13: got %h want deadbeef", rd); end
        a = 32'h5000; #1;
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL unmapped_5000: got %h want 0", rd); end
        // Read during write returns old contents
        a = 32'h10; we = 1'b1; wd = 32'h1234_5678; #1;
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ram_rdw_old: got %h want deadbeef", rd); end
        @(negedge clk);
        we = 1'b0; #1;
        n_checks++; if (rd !== 32'h1234_5678) begin n_errors++; $display("FAIL ram_rdw_new: got %h want 12345678", rd); end
        // Top word, then a write just past the RAM must not alias word 0
        we = 1'b1; a = 32'hFC; wd = 32'hA0A0_0FFC;
        @(negedge clk);
        a = 32'h0; wd = 32'h0BAD_0000;
        @(negedge clk);
        a = 32'h100; wd = 32'hFFFF_FFFF;
        @(negedge clk);
        we = 1'b0; a = 32'hFC; #1;
        n_checks++; if (rd !== 32'hA0A0_0FFC) begin n_errors++; $display("FAIL ram_top_word: got %h want a0a00ffc", rd); end
        a = 32'h0; #1;
        n_checks++; if (rd !== 32'h0BAD_0000) begin n_errors++; $display("FAIL ram_no_alias: got %h want 0bad0000", rd); end
        a = 32'h100; #1;
        n_checks++; if (rd !== 32'd0) begin n_errors++; $display("FAIL ram_past_end: got %h want 0", rd); end
    endtask

    task automatic test_led();
        @(negedge clk);
        we = 1'b1; a = A_LED; wd = 32'h1A5;
        @(negedge clk);
        we = 1'b0; #1;
        n_checks++; if (leds !== 8'hA5) begin n_errors++; $display("FAIL led_out: got %h want a5", leds); end
        n_checks++; if (rd !== 32'hA5) begin n_errors++; $display("FAIL led_read: got %h want 000000a5", rd); end
        #1 reset = 1'b0; #1;
        n_checks++; if (leds !== 8'h00) begin n_errors++; $display("FAIL led_async_reset: got %h want 00", leds); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            we = 1'b1; a = A_TXD; wd = 32'(i);
        end
        @(negedge clk);
        we = 1'b0; a = A_STAT; #1;
        n_checks++; if (rd !== 32'h31) begin n_errors++; $display("FAIL ovf_stat_full: got %h want 31", rd); end
        n_checks++; if (tx_data !== 32'd1) begin n_errors++; $display("FAIL ovf_head: got %h want 1", tx_data); end
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 32'(i)) begin
                n_errors++; $display("FAIL ovf_pop_%0d: got valid %b data %h want valid 1 data %h", i, tx_valid, tx_data, i);
            end
            @(negedge clk); #1;
        end
        n_checks++; if (rd !== 32'h22) begin n_errors++; $display("FAIL ovf_stat_empty: got %h want 22", rd); end
        tx_ready = 1'b0; we = 1'b1; wd = 32'h20;
        @(negedge clk);
        we = 1'b0; #1;
        n_checks++; if (rd !== 32'h02) begin n_errors++; $display("FAIL ovf_clear: got %h want 02", rd); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'd12; exp_seq[1] = 32'd13; exp_seq[2] = 32'd14; exp_seq[3] = 32'd9;
        tx_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            @(negedge clk);
            we = 1'b1; a = A_TXD; wd = 32'(i);
        end
        @(negedge clk);
        tx_ready = 1'b1; we = 1'b1; a = A_TXD; wd = 32'd9; #1;
        n_checks++; if (tx_data !== 32'd11) begin n_errors++; $display("FAIL fpp_head: got %h want 0b", tx_data); end
        @(negedge clk);
        we = 1'b0; a = A_STAT; #1;
        n_checks++; if (rd !== 32'h11) begin n_errors++; $display("FAIL fpp_stat: got %h want 11", rd); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_seq[i]) begin
                n_errors++; $display("FAIL fpp_seq_%0d: got valid %b data %h want %h", i, tx_valid, tx_data, exp_seq[i]);
            end
            @(negedge clk); #1;
        end
        n_checks++; if (tx_valid !== 1'b0 || rd !== 32'h02) begin n_errors++; $display("FAIL fpp_drained: got valid %b stat %h want 0/02", tx_valid, rd); end
    endtask

    task automatic test_empty_push();
        @(negedge clk);
        tx_ready = 1'b1; we = 1'b1; a = A_TXD; wd = 32'd7; #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL ep_no_valid: got %b want 0", tx_valid); end
        @(negedge clk);
        we = 1'b0; a = A_STAT; #1;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 32'd7) begin n_errors++; $display("FAIL ep_valid: got valid %b data %h want 1/7", tx_valid, tx_data); end
        @(negedge clk); #1;
        n_checks++; if (tx_valid !== 1'b0 || rd !== 32'h02) begin n_errors++; $display("FAIL ep_empty: got valid %b stat %h want 0/02", tx_valid, rd); end
        tx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] unmapped [4];
        logic [31:0] exp_rd;
        bit          known;
        bit          pop;
        int          op;
        unmapped[0] = 32'hFFFF_0010; unmapped[1] = 32'h8000_0000;
        unmapped[2] = 32'h0000_0104; unmapped[3] = 32'hFFFE_0000;
        @(negedge clk);
        reset = 1'b0; we = 1'b0;
        #1 reset = 1'b1;
        m_q.delete(); m_leds = 8'd0; m_ovf = 1'b0;
        for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            op = $urandom_range(0, 7);
            tx_ready = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            case (op)
                0, 1:    a = 32'($urandom_range(0, 255));
                2:       a = A_LED + 32'($urandom_range(0, 3));
                3, 4:    a = A_TXD;
                5:       begin a = A_STAT; wd[5] = ($urandom_range(0, 3) == 0); end
                default: a = unmapped[$urandom_range(0, 3)];
            endcase
            #1;
            known = 1'b1; exp_rd = 32'd0;
            if (a < 32'd256) begin
                known = m_ram_ok[a[7:2]]; exp_rd = m_ram[a[7:2]];
            end else if (a[31:2] == A_LED[31:2]) begin
                exp_rd = {24'd0, m_leds};
            end else if (a[31:2] == A_STAT[31:2]) begin
                exp_rd = 32'(m_ovf) * 32 + 32'(m_q.size()) * 4
                       + ((m_q.size() == 0) ? 32'd2 : 32'd0) + ((m_q.size() == 4) ? 32'd1 : 32'd0);
            end
            if (known) begin
                n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL rnd_rd cyc %0d a=%h: got %h want %h", cyc, a, rd, exp_rd); end
            end
            n_checks++;
            if (tx_valid !== (m_q.size() != 0) || tx_data !== ((m_q.size() != 0) ? m_q[0] : 32'd0)) begin
                n_errors++; $display("FAIL rnd_tx cyc %0d: got valid %b data %h want size %0d", cyc, tx_valid, tx_data, m_q.size());
            end
            n_checks++; if (leds !== m_leds) begin n_errors++; $display("FAIL rnd_leds cyc %0d: got %h want %h", cyc, leds, m_leds); end
            // Apply the upcoming edge to the model
            pop = (m_q.size() != 0) && tx_ready;
            if (pop) void'(m_q.pop_front());
            if (we) begin
                if (a < 32'd256) begin m_ram[a[7:2]] = wd; m_ram_ok[a[7:2]] = 1'b1; end
                else if (a[31:2] == A_LED[31:2]) m_leds = wd[7:0];
                else if (a[31:2] == A_STAT[31:2] && wd[5]) m_ovf = 1'b0;
                else if (a[31:2] == A_TXD[31:2]) begin
                    if (m_q.size() < 4) m_q.push_back(wd);
                    else m_ovf = 1'b1;
                end
            end
        end
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_ram();
        test_led();
        test_overflow();
        test_full_push_pop();
        test_empty_push();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
